// File: rtl/resp_pkg.sv
// Shared types and constants for the I2C result to UART framing path.
package resp_pkg;

   // Frame sequencer states: wait for a result, then header, data high, data low.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DHI  = 2'd2,
      DLO  = 2'd3
   } state_e;

   // One completed I2C transaction as stored in the response FIFO.
   typedef struct packed {
      logic [1:0]  tag;
      logic [2:0]  mode;
      logic [15:0] data;
   } resp_t;

   localparam logic [1:0] TAG_QUEUED  = 2'b01;
   localparam logic [1:0] TAG_DEFAULT = 2'b11;
   localparam int         FRAME_BYTES = 3;
   localparam int         RESP_W      = $bits(resp_t);

   // Byte idx of the UART frame for a result: 0 header, 1 data high, 2 data low.
   function automatic logic [7:0] frame_byte(input logic [2:0] sync,
                                             input resp_t      r,
                                             input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = {sync, r.tag, r.mode};
         2'd1:    b = r.data[15:8];
         default: b = r.data[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous-reset FIFO holding completed I2C results until they are framed.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module resp_fifo #(
   parameter  int WIDTH = 21,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_accept;
   logic             rd_accept;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign rd_accept = rd_en && !empty;
   assign wr_accept = wr_en && (!full || rd_accept);
   // Head entry is read combinationally; the consumer registers it on pop.
   assign rd_data   = mem[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array, written without reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr_q] <= wr_data;
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/i2c_uart_responder.sv
// Queues I2C transaction results and streams each one to a UART transmitter
// as a three-byte frame: {SYNC, tag, mode}, data[15:8], data[7:0].
module i2c_uart_responder
   import resp_pkg::*;
#(
   parameter int         DEPTH = 4,
   parameter logic [2:0] SYNC  = 3'b101
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i2c_done,
   input  logic [15:0] i2c_rd_data,
   input  logic [1:0]  i2c_tag,
   input  logic [2:0]  i2c_mode,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        resp_full,
   output logic        resp_overflow
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [RESP_W-1:0] fifo_wr_data;
   logic [RESP_W-1:0] fifo_rd_data;
   logic              fifo_rd_en;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;

   state_e     state_q, state_d;
   resp_t      frame_q, frame_d;
   logic       tx_valid_q, tx_valid_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       overflow_q, overflow_d;

   assign fifo_wr_data = {i2c_tag, i2c_mode, i2c_rd_data};

   resp_fifo #(
      .WIDTH (RESP_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (i2c_done),
      .wr_data (fifo_wr_data),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Full flag comes straight from the registered occupancy count.
   assign resp_full     = (fifo_count == DEPTH_C);
   assign tx_valid      = tx_valid_q;
   assign tx_data       = tx_data_q;
   assign resp_overflow = overflow_q;

   // Frame sequencing: the outgoing byte is computed one step ahead so that
   // tx_valid/tx_data come directly from flops and hold steady under stall.
   always_comb begin
      fifo_rd_en = 1'b0;
      state_d    = state_q;
      frame_d    = frame_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               frame_d    = resp_t'(fifo_rd_data);
               state_d    = HDR;
               tx_valid_d = 1'b1;
               tx_data_d  = frame_byte(SYNC, resp_t'(fifo_rd_data), 2'd0);
            end
         end
         HDR: begin
            if (tx_ready) begin
               state_d   = DHI;
               tx_data_d = frame_byte(SYNC, frame_q, 2'd1);
            end
         end
         DHI: begin
            if (tx_ready) begin
               state_d   = DLO;
               tx_data_d = frame_byte(SYNC, frame_q, 2'd2);
            end
         end
         DLO: begin
            if (tx_ready) begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
               tx_data_d  = 8'h00;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase
      // A result is lost only when full and nothing leaves on the same edge.
      overflow_d = overflow_q | (i2c_done & fifo_full & ~fifo_rd_en);
   end

   // FSM state, frame register, registered UART outputs and sticky overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         frame_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_i2c_uart_responder.sv
// Directed bench for i2c_uart_responder: latency, stall, overflow,
// full-with-pop, reset mid-frame and back-to-back framing.
module tb_i2c_uart_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        i2c_done;
   logic [15:0] i2c_rd_data;
   logic [1:0]  i2c_tag;
   logic [2:0]  i2c_mode;
   logic        tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        resp_full;
   logic        resp_overflow;

   int checks = 0;
   int passed = 0;

   logic [7:0] cap [32];
   int         cap_n;

   i2c_uart_responder #(.DEPTH(4), .SYNC(3'b101)) dut (
      .clk           (clk),
      .reset         (reset),
      .i2c_done      (i2c_done),
      .i2c_rd_data   (i2c_rd_data),
      .i2c_tag       (i2c_tag),
      .i2c_mode      (i2c_mode),
      .tx_ready      (tx_ready),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .resp_full     (resp_full),
      .resp_overflow (resp_overflow)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled at negedge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; i2c_done = 1'b0; tx_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic set_push(input logic [1:0] tag, input logic [2:0] mode, input logic [15:0] d);
      i2c_done = 1'b1; i2c_tag = tag; i2c_mode = mode; i2c_rd_data = d;
   endtask

   // Accept bytes with tx_ready=1 until n are captured or the budget expires.
   task automatic gather(input int n, input int budget);
      cap_n = 0;
      tx_ready = 1'b1;
      for (int c = 0; c < budget && cap_n < n; c++) begin
         if (tx_valid) begin
            cap[cap_n] = tx_data;
            cap_n++;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; i2c_done = 1'b0; tx_ready = 1'b0;
      i2c_rd_data = 16'h0; i2c_tag = 2'b00; i2c_mode = 3'b000;
      @(negedge clk); tick(); tick();
      checks++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else passed++;
      checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", tx_data); else passed++;
      checks++; if (resp_full !== 1'b0) $display("FAIL reset_full: got %b want 0", resp_full); else passed++;
      checks++; if (resp_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", resp_overflow); else passed++;
      reset = 1'b0;
      tick();
      checks++; if (tx_valid !== 1'b0) $display("FAIL idle_tx_valid: got %b want 0", tx_valid); else passed++;
   endtask

   // Header for tag 11, mode 001 with SYNC 101 is 1011_1001 = 8'hB9.
   task automatic test_single();
      tx_ready = 1'b1;
      set_push(2'b11, 3'b001, 16'h1A80);
      tick(); i2c_done = 1'b0;
      checks++; if (tx_valid !== 1'b0) $display("FAIL single_n1_valid: got %b want 0", tx_valid); else passed++;
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hB9) $display("FAIL single_hdr: got %b/%h want 1/b9", tx_valid, tx_data); else passed++;
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h1A) $display("FAIL single_dhi: got %b/%h want 1/1a", tx_valid, tx_data); else passed++;
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h80) $display("FAIL single_dlo: got %b/%h want 1/80", tx_valid, tx_data); else passed++;
      tick();
      checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL single_end: got %b/%h want 0/00", tx_valid, tx_data); else passed++;
   endtask

   task automatic test_backpressure();
      int bad;
      tx_ready = 1'b1;
      set_push(2'b11, 3'b001, 16'h1A80);
      tick(); i2c_done = 1'b0;
      tick();
      checks++; if (tx_data !== 8'hB9) $display("FAIL bp_hdr: got %h want b9", tx_data); else passed++;
      tick();
      tx_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (tx_valid !== 1'b1 || tx_data !== 8'h1A) bad++;
         tick();
      end
      checks++; if (bad != 0) $display("FAIL bp_hold: got %0d bad cycles want 0 (last %b/%h)", bad, tx_valid, tx_data); else passed++;
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h1A) $display("FAIL bp_still_dhi: got %b/%h want 1/1a", tx_valid, tx_data); else passed++;
      tx_ready = 1'b1;
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h80) $display("FAIL bp_dlo: got %b/%h want 1/80", tx_valid, tx_data); else passed++;
      tick();
      checks++; if (tx_valid !== 1'b0) $display("FAIL bp_end: got %b want 0", tx_valid); else passed++;
   endtask

   // A frame stalls in HDR, then five results arrive; only four fit.
   task automatic test_overflow();
      logic [7:0] exp_b [15];
      exp_b = '{8'hB8, 8'hF0, 8'h0F, 8'hA9, 8'hC0, 8'h30, 8'hBA, 8'hC1, 8'h31,
                8'hAB, 8'hC2, 8'h32, 8'hBC, 8'hC3, 8'h33};
      do_reset();
      tx_ready = 1'b0;
      set_push(2'b11, 3'b000, 16'hF00F);
      tick(); i2c_done = 1'b0;
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hB8) $display("FAIL ovf_stall_hdr: got %b/%h want 1/b8", tx_valid, tx_data); else passed++;
      for (int i = 0; i < 5; i++) begin
         set_push((i % 2 == 0) ? 2'b01 : 2'b11, 3'(i + 1), {8'(8'hC0 + i), 8'(8'h30 + i)});
         tick();
         checks++; if (resp_full !== (i >= 3)) $display("FAIL ovf_full_%0d: got %b want %b", i, resp_full, (i >= 3)); else passed++;
         checks++; if (resp_overflow !== (i == 4)) $display("FAIL ovf_flag_%0d: got %b want %b", i, resp_overflow, (i == 4)); else passed++;
      end
      i2c_done = 1'b0;
      gather(15, 60);
      checks++; if (cap_n != 15) $display("FAIL ovf_count: got %0d bytes want 15", cap_n); else passed++;
      for (int i = 0; i < cap_n && i < 15; i++) begin
         checks++; if (cap[i] !== exp_b[i]) $display("FAIL ovf_byte_%0d: got %h want %h", i, cap[i], exp_b[i]); else passed++;
      end
      gather(3, 10);
      checks++; if (cap_n != 0) $display("FAIL ovf_extra: got %0d extra bytes want 0", cap_n); else passed++;
      checks++; if (resp_overflow !== 1'b1 || resp_full !== 1'b0) $display("FAIL ovf_after: got ovf %b full %b want 1/0", resp_overflow, resp_full); else passed++;
   endtask

   // FIFO full, then a result arrives on the same edge as the IDLE pop.
   task automatic test_full_with_pop();
      logic [7:0] exp_b [15];
      bool_found: begin end
      exp_b = '{8'hB8, 8'h40, 8'h50, 8'hB9, 8'h41, 8'h51, 8'hBA, 8'h42, 8'h52,
                8'hBB, 8'h43, 8'h53, 8'hAE, 8'h77, 8'h88};
      do_reset();
      tx_ready = 1'b0;
      set_push(2'b01, 3'b111, 16'h1122);
      tick(); i2c_done = 1'b0;
      tick();
      checks++; if (tx_data !== 8'hAF) $display("FAIL fwp_hdr: got %h want af", tx_data); else passed++;
      for (int j = 0; j < 4; j++) begin
         set_push(2'b11, 3'(j), {8'(8'h40 + j), 8'(8'h50 + j)});
         tick();
      end
      i2c_done = 1'b0;
      checks++; if (resp_full !== 1'b1) $display("FAIL fwp_full: got %b want 1", resp_full); else passed++;
      tx_ready = 1'b1;
      begin
         int found;
         found = 0;
         for (int c = 0; c < 10 && found == 0; c++) begin
            if (tx_valid === 1'b0) found = 1;
            else tick();
         end
         checks++; if (found != 1) $display("FAIL fwp_idle: got no idle cycle want one"); else passed++;
      end
      set_push(2'b01, 3'b110, 16'h7788);
      tick(); i2c_done = 1'b0;
      checks++; if (resp_full !== 1'b1) $display("FAIL fwp_still_full: got %b want 1", resp_full); else passed++;
      checks++; if (resp_overflow !== 1'b0) $display("FAIL fwp_no_ovf: got %b want 0", resp_overflow); else passed++;
      gather(15, 60);
      checks++; if (cap_n != 15) $display("FAIL fwp_count: got %0d bytes want 15", cap_n); else passed++;
      for (int i = 0; i < cap_n && i < 15; i++) begin
         checks++; if (cap[i] !== exp_b[i]) $display("FAIL fwp_byte_%0d: got %h want %h", i, cap[i], exp_b[i]); else passed++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      do_reset();
      tx_ready = 1'b1;
      set_push(2'b11, 3'b001, 16'h1A80);
      tick(); i2c_done = 1'b0;
      tick(); tick();
      checks++; if (tx_data !== 8'h1A) $display("FAIL rmf_dhi: got %h want 1a", tx_data); else passed++;
      reset = 1'b1;
      set_push(2'b01, 3'b000, 16'hDEAD);
      tick();
      reset = 1'b0; i2c_done = 1'b0;
      checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL rmf_valid: got %b/%h want 0/00", tx_valid, tx_data); else passed++;
      checks++; if (resp_full !== 1'b0) $display("FAIL rmf_full: got %b want 0", resp_full); else passed++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (tx_valid !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) $display("FAIL rmf_quiet: got %0d valid cycles want 0", bad); else passed++;
      set_push(2'b01, 3'b010, 16'h5A3C);
      tick(); i2c_done = 1'b0;
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hAA) $display("FAIL rmf_hdr: got %b/%h want 1/aa", tx_valid, tx_data); else passed++;
      tick();
      checks++; if (tx_data !== 8'h5A) $display("FAIL rmf_dhi2: got %h want 5a", tx_data); else passed++;
      tick();
      checks++; if (tx_data !== 8'h3C) $display("FAIL rmf_dlo2: got %h want 3c", tx_data); else passed++;
      tick();
   endtask

   // Two results on consecutive cycles: one IDLE cycle separates the frames.
   task automatic test_back_to_back();
      logic       exp_v [8];
      logic [7:0] exp_d [8];
      exp_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_d = '{8'hB9, 8'h1A, 8'h80, 8'h00, 8'hAB, 8'h01, 8'h02, 8'h00};
      do_reset();
      tx_ready = 1'b1;
      set_push(2'b11, 3'b001, 16'h1A80);
      tick();
      set_push(2'b01, 3'b011, 16'h0102);
      tick();
      i2c_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tx_valid !== exp_v[i] || tx_data !== exp_d[i])
            $display("FAIL b2b_cycle_%0d: got %b/%h want %b/%h", i, tx_valid, tx_data, exp_v[i], exp_d[i]);
         else passed++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_overflow();
      test_full_with_pop();
      test_reset_mid_frame();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Hard stop in case a task never returns.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
